// File: rtl/unary_block_acc_if.sv
// unary_block_acc_if -- handshake bundle between a unary beat source, the
// unary_block_acc converter, and the consumer of its binary result.
//   u_in/u_in_valid/u_done : unary beat stream and end-of-frame marker
//   u_in_ready              : converter can take a beat or done this cycle
//   bin_out/bin_out_valid   : frame count and its qualifier
//   bin_out_ready           : consumer accepts the result
//   overflow/code_err       : frame status flags, qualified by bin_out_valid
// Modport slave is the converter side, master is the environment side.
interface unary_block_acc_if #(
  parameter int unsigned UWIDTH = 2,
  parameter int unsigned BWIDTH = 4
);
  logic [UWIDTH-1:0] u_in;
  logic              u_in_valid;
  logic              u_done;
  logic              u_in_ready;
  logic [BWIDTH-1:0] bin_out;
  logic              bin_out_valid;
  logic              bin_out_ready;
  logic              overflow;
  logic              code_err;

  modport slave (
    input  u_in, u_in_valid, u_done, bin_out_ready,
    output u_in_ready, bin_out, bin_out_valid, overflow, code_err
  );

  modport master (
    output u_in, u_in_valid, u_done, bin_out_ready,
    input  u_in_ready, bin_out, bin_out_valid, overflow, code_err
  );
endinterface

// File: rtl/unary_block_acc.sv
// unary_block_acc -- accumulates thermometer-coded unary beats into a
// saturating binary frame count and presents it with a valid/ready handshake.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : unary_block_acc_if.slave (beat stream in, result out)
module unary_block_acc #(
  parameter int unsigned UWIDTH = 2,
  parameter int unsigned BWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  unary_block_acc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Sum width leaves headroom so saturation can be detected before truncation.
  localparam int unsigned SW = BWIDTH + UWIDTH;
  localparam logic [SW-1:0] MAX = {{UWIDTH{1'b0}}, {BWIDTH{1'b1}}};

  state_t            r_state;
  logic [BWIDTH-1:0] r_acc;
  logic              r_valid;
  logic              r_ready;
  logic              r_ovf;
  logic              r_err;

  logic [SW-1:0]     w_pop;
  logic [SW-1:0]     w_sum;
  logic [UWIDTH-1:0] w_inc;
  logic              w_bad;
  logic              w_accept;
  logic              w_done;

  assign w_accept = bus.u_in_valid & r_ready;
  assign w_done   = bus.u_done & r_ready;

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < UWIDTH; i++) begin
      w_pop = w_pop + SW'(bus.u_in[i]);
    end
    w_sum = SW'(r_acc) + w_pop;
    // A thermometer code plus one is a power of two (or wraps to 0), so it
    // shares no set bit with the original; any overlap means a 1 above a 0.
    w_inc = bus.u_in + UWIDTH'(1);
    w_bad = |(bus.u_in & w_inc);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            if (w_sum > MAX) begin
              r_acc <= '1;
              r_ovf <= 1'b1;
            end else begin
              r_acc <= w_sum[BWIDTH-1:0];
            end
            if (w_bad) r_err <= 1'b1;
          end
          if (w_done) begin
            r_state <= HOLD;
            r_valid <= 1'b1;
            r_ready <= 1'b0;
          end else if (w_accept) begin
            r_state <= ACCUM;
          end
        end
        HOLD: begin
          if (bus.bin_out_ready) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.u_in_ready    = r_ready;
  assign bus.bin_out       = r_acc;
  assign bus.bin_out_valid = r_valid;
  assign bus.overflow      = r_ovf;
  assign bus.code_err      = r_err;

endmodule

// File: tb/tb_unary_block_acc.sv
// Bench for unary_block_acc (UWIDTH=2, BWIDTH=4): directed frames driven on
// the falling edge, a frame-level reference model, a per-cycle compare, and
// literal expectations for each directed frame.
module tb_unary_block_acc;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  bit   chk_en;

  // Frame-level reference state: raw (unsaturated) beat total, error seen,
  // and whether a finished frame is waiting for the consumer.
  int   m_sum;
  bit   m_err;
  bit   m_hold;

  unary_block_acc_if #(.UWIDTH(2), .BWIDTH(4)) bus ();

  unary_block_acc #(.UWIDTH(2), .BWIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_thermo(input logic [1:0] u);
    int pc;
    pc = $countones(u);
    return (int'(u) == (1 << pc) - 1);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sum  = 0;
      m_err  = 1'b0;
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (bus.u_in_valid) begin
        m_sum = m_sum + $countones(bus.u_in);
        if (!is_thermo(bus.u_in)) m_err = 1'b1;
      end
      if (bus.u_done) m_hold = 1'b1;
    end else if (bus.bin_out_ready) begin
      m_sum  = 0;
      m_err  = 1'b0;
      m_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready",    int'(bus.u_in_ready),    int'(!m_hold));
      check("valid",    int'(bus.bin_out_valid), int'(m_hold));
      check("bin_out",  int'(bus.bin_out),       (m_sum > 15) ? 15 : m_sum);
      check("overflow", int'(bus.overflow),      int'(m_sum > 15));
      check("code_err", int'(bus.code_err),      int'(m_err));
    end
  end

  task automatic drive(input logic [1:0] u, input logic v, input logic d);
    @(negedge clk);
    #1;
    bus.u_in       = u;
    bus.u_in_valid = v;
    bus.u_done     = d;
  endtask

  // Called right after the done beat was driven: the result must be visible
  // one edge later, then it is released with a one-cycle ready.
  task automatic finish_frame(input string tag, input int eb, input int eo, input int ee);
    drive(2'b00, 1'b0, 1'b0);
    check({tag, "_valid"}, int'(bus.bin_out_valid), 1);
    check({tag, "_bin"},   int'(bus.bin_out),       eb);
    check({tag, "_ovf"},   int'(bus.overflow),      eo);
    check({tag, "_err"},   int'(bus.code_err),      ee);
    bus.bin_out_ready = 1'b1;
    @(negedge clk);
    #1;
    bus.bin_out_ready = 1'b0;
    check({tag, "_released"}, int'(bus.bin_out_valid), 0);
    check({tag, "_cleared"},  int'(bus.bin_out),       0);
    check({tag, "_idle_rdy"}, int'(bus.u_in_ready),    1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    bus.u_in = 2'b00;
    bus.u_in_valid = 1'b0;
    bus.u_done = 1'b0;
    bus.bin_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", int'(bus.u_in_ready),    1);
    check("rst_valid", int'(bus.bin_out_valid), 0);
    check("rst_bin",   int'(bus.bin_out),       0);
    check("rst_ovf",   int'(bus.overflow),      0);
    check("rst_err",   int'(bus.code_err),      0);
    #1;
    chk_en = 1'b1;

    // First beat presented together with reset release: taken on first edge.
    reset = 1'b0;
    bus.u_in = 2'b11;
    bus.u_in_valid = 1'b1;
    drive(2'b01, 1'b1, 1'b0);
    drive(2'b11, 1'b1, 1'b1);
    finish_frame("f5", 5, 0, 0);

    for (int i = 0; i < 9; i++) drive(2'b11, 1'b1, (i == 8));
    finish_frame("f_sat", 15, 1, 0);

    // Exactly full without overflow: 7*2 + 1 = 15.
    for (int i = 0; i < 7; i++) drive(2'b11, 1'b1, 1'b0);
    drive(2'b01, 1'b1, 1'b1);
    finish_frame("f15", 15, 0, 0);

    drive(2'b10, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 1'b1);
    finish_frame("f_err", 1, 0, 1);

    drive(2'b11, 1'b1, 1'b0);
    drive(2'b00, 1'b1, 1'b1);
    finish_frame("f_zero_beat", 2, 0, 0);

    // Done alone in IDLE, then a stalled result with input pressure.
    drive(2'b00, 1'b0, 1'b1);
    drive(2'b11, 1'b1, 1'b1);
    check("empty_valid", int'(bus.bin_out_valid), 1);
    check("empty_bin",   int'(bus.bin_out),       0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ready", int'(bus.u_in_ready),    0);
      check("stall_bin",   int'(bus.bin_out),       0);
      check("stall_valid", int'(bus.bin_out_valid), 1);
    end
    #1;
    bus.u_in_valid = 1'b0;
    bus.u_done = 1'b0;
    bus.bin_out_ready = 1'b1;
    @(negedge clk);
    #1;
    bus.bin_out_ready = 1'b0;
    check("stall_rel_valid", int'(bus.bin_out_valid), 0);
    check("stall_rel_bin",   int'(bus.bin_out),       0);
    check("stall_rel_ready", int'(bus.u_in_ready),    1);

    // Reset mid-frame discards the partial count.
    for (int i = 0; i < 3; i++) drive(2'b01, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    bus.u_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_bin",   int'(bus.bin_out),       0);
    check("midrst_valid", int'(bus.bin_out_valid), 0);
    check("midrst_ready", int'(bus.u_in_ready),    1);
    #1;
    reset = 1'b0;
    bus.u_in = 2'b01;
    bus.u_in_valid = 1'b1;
    bus.u_done = 1'b1;
    finish_frame("post_rst", 1, 0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/unary_block_acc.md
UNARY_BLOCK_ACC -- requirements
Module: unary_block_acc

Interface
REQ-001 SHALL have parameter UWIDTH, default 2, the number of unary lanes per beat (thermometer-coded, LSB first).
REQ-002 SHALL have parameter BWIDTH, default 4, the width of the binary accumulator and result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port u_in, input, UWIDTH, the unary beat from the upstream generator.
REQ-006 SHALL have port u_in_valid, input, 1, qualifying u_in.
REQ-007 SHALL have port u_done, input, 1, marking the last beat of a frame; it may be high with or without u_in_valid.
REQ-008 SHALL have port u_in_ready, output, 1, signalling that the block accepts a beat or done this cycle.
REQ-009 SHALL have port bin_out, output, BWIDTH, the accumulated binary count of the frame.
REQ-010 SHALL have port bin_out_valid, output, 1, qualifying bin_out.
REQ-011 SHALL have port bin_out_ready, input, 1, downstream acceptance of bin_out.
REQ-012 SHALL have port overflow, output, 1, set when the frame count saturated.
REQ-013 SHALL have port code_err, output, 1, set when any accepted beat was not thermometer-coded.

Function
REQ-014 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-015 SHALL drive u_in_ready high in IDLE and ACCUM and low in HOLD.
REQ-016 SHALL treat a beat as accepted only when u_in_valid and u_in_ready are both high; u_done counts only when u_in_ready is high.
REQ-017 SHALL add popcount(u_in) of each accepted beat to the accumulator, registered on the same edge.
REQ-018 SHALL saturate the accumulator at 2^BWIDTH-1 and set overflow whenever a sum would exceed that value.
REQ-019 SHALL set code_err when an accepted u_in has a 1 above a 0 (not of the form 0..01..1); the popcount is still added.
REQ-020 IDLE: on an accepted beat without u_done, the block SHALL go to ACCUM; on u_done, it SHALL go to HOLD.
REQ-021 ACCUM: on u_done, the block SHALL go to HOLD; otherwise it SHALL remain in ACCUM.
REQ-022 When u_done and u_in_valid are high in the same cycle, that beat SHALL be included in the result.
REQ-023 When u_done arrives alone in IDLE, the result SHALL be a frame count of 0.
REQ-024 HOLD: bin_out_valid SHALL be high, and bin_out, overflow and code_err SHALL be held stable until bin_out_ready is high.
REQ-025 On the HOLD handshake, the block SHALL clear the accumulator, overflow and code_err, and return to IDLE on the next edge.
REQ-026 bin_out_valid SHALL rise on the edge after u_done is accepted, so latency is 1 cycle from the last beat to the result.
REQ-027 bin_out SHALL equal the accumulator in every state; it is meaningful only while bin_out_valid is high.
REQ-028 Inputs SHALL be ignored in HOLD; a u_in_valid or u_done presented there SHALL not alter state, because the upstream block is stalled by u_in_ready low.
REQ-029 Re-acceptance SHALL need at least one IDLE cycle after HOLD; no same-cycle HOLD-to-new-frame bypass.

Reset
REQ-030 While reset is high, the block SHALL force state IDLE, accumulator 0, bin_out_valid 0, overflow 0, code_err 0 and u_in_ready 1, asynchronously.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result, and no bin_out_valid pulse SHALL follow.
REQ-032 The first beat SHALL be accepted on the first rising edge after reset deasserts.

Verification (UWIDTH=2, BWIDTH=4)
REQ-033 Beats 2'b11, 2'b01, 2'b11 with u_done on the third beat -> bin_out=5, bin_out_valid high 1 cycle later, overflow=0, code_err=0.
REQ-034 Nine beats of 2'b11 with done on the last -> bin_out=15, overflow=1.
REQ-035 A beat of 2'b10 then done alone -> bin_out=1, code_err=1.
REQ-036 u_done alone in IDLE -> bin_out=0, bin_out_valid=1. Then hold bin_out_ready low for 5 cycles while driving u_in_valid -> u_in_ready=0 and outputs stable; on ready the block returns to IDLE with the accumulator at 0.
REQ-037 Reset pulsed after 3 beats of 2'b01 -> all outputs at reset values; a following beat 2'b01 with done -> bin_out=1.
